// File: rtl/mem_access_unit.sv
// Purpose : RV32I load/store unit in front of a single-port word memory (no byte enables).
// Latency : load RD_LATENCY+1, SW 2, SB/SH RD_LATENCY+2, fault 1 cycle(s) from accept to resp_valid.
// Backpr. : one request in flight; req_ready low while busy; resp_* is a one-cycle pulse with no backpressure.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   req_valid/req_ready        - request handshake (accept when both high)
//   req_store, req_funct3      - operation select (RV32I funct3 encoding)
//   req_addr, req_wdata, req_rd- byte address, store data, destination tag
//   resp_valid                 - completion pulse qualifying resp_rdata/resp_rd/resp_fault
//   mem_address, mem_we        - word address (low two bits zero) and write enable
//   mem_data_out, mem_data_in  - write data (zero when not writing) and read data
module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_out,
  input  logic [31:0]       mem_data_in,
  output logic              mem_we
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Last value of the READ-cycle counter; the read word is taken on the
  // edge that ends the cycle in which the counter equals this value.
  localparam logic [3:0] LAT_LAST = 4'(RD_LATENCY - 1);

  state_t      state;
  logic [3:0]  lat_cnt;

  // Captured request. Only the byte lane of the address is kept here because
  // the word part lives in mem_address for the whole memory access. Only the
  // low halfword of store data is kept: a full-word store is issued straight
  // from req_wdata at accept and never needs it later.
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_lo_q;
  logic [4:0]  rd_q;

  logic        accept;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_fault;
  logic        req_is_sw;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] st_merged;

  assign accept = req_valid && req_ready;

  // Fault classification of the incoming request, evaluated only at accept.
  always_comb begin
    req_illegal = 1'b0;
    if (req_store) begin
      req_illegal = (req_funct3 > 3'd2);
    end else begin
      req_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end
  end

  // funct3[1:0] gives the access size for every legal code (LBU/LHU share
  // it with LB/LH); for illegal codes the misalignment term is irrelevant.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'd1:    req_misaligned = req_addr[0];
      2'd2:    req_misaligned = (req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  assign req_fault = req_illegal || req_misaligned;
  assign req_is_sw = req_store && (req_funct3 == 3'd2);

  // Lane selection from the word currently presented by memory.
  always_comb begin
    ld_byte = mem_data_in[7:0];
    case (lane_q)
      2'd0: ld_byte = mem_data_in[7:0];
      2'd1: ld_byte = mem_data_in[15:8];
      2'd2: ld_byte = mem_data_in[23:16];
      2'd3: ld_byte = mem_data_in[31:24];
      default: ld_byte = mem_data_in[7:0];
    endcase
    ld_half = lane_q[1] ? mem_data_in[31:16] : mem_data_in[15:0];
  end

  // Sign or zero extension according to the captured load type.
  always_comb begin
    ld_ext = mem_data_in;
    case (funct3_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_data_in;
    endcase
  end

  // Read-modify-write merge for SB/SH: the addressed lane takes the new
  // data, every other byte of the word read back is preserved.
  always_comb begin
    st_merged = mem_data_in;
    if (funct3_q[1:0] == 2'd0) begin
      case (lane_q)
        2'd0: st_merged[7:0]   = wdata_lo_q[7:0];
        2'd1: st_merged[15:8]  = wdata_lo_q[7:0];
        2'd2: st_merged[23:16] = wdata_lo_q[7:0];
        2'd3: st_merged[31:24] = wdata_lo_q[7:0];
        default: st_merged = mem_data_in;
      endcase
    end else begin
      if (lane_q[1]) begin
        st_merged[31:16] = wdata_lo_q;
      end else begin
        st_merged[15:0]  = wdata_lo_q;
      end
    end
  end

  // Control FSM. All outputs are registered so that each state's output
  // values appear in the cycle the state is occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lat_cnt      <= 4'd0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_rd      <= 5'd0;
      resp_fault   <= 1'b0;
      mem_address  <= '0;
      mem_data_out <= 32'd0;
      mem_we       <= 1'b0;
      store_q      <= 1'b0;
      funct3_q     <= 3'd0;
      lane_q       <= 2'd0;
      wdata_lo_q   <= 16'd0;
      rd_q         <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            store_q    <= req_store;
            funct3_q   <= req_funct3;
            lane_q     <= req_addr[1:0];
            wdata_lo_q <= req_wdata[15:0];
            rd_q       <= req_rd;
            req_ready  <= 1'b0;
            if (req_fault) begin
              // Faults skip memory entirely; mem_address stays zero.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= 32'd0;
              resp_rd    <= req_rd;
            end else begin
              mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
              lat_cnt     <= 4'd0;
              if (req_is_sw) begin
                // Full-word store needs no read-back.
                state        <= WRITE;
                mem_we       <= 1'b1;
                mem_data_out <= req_wdata;
              end else begin
                state <= READ;
              end
            end
          end
        end

        READ: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= 4'd0;
            if (store_q) begin
              // Same word address stays up for the write-back.
              state        <= WRITE;
              mem_we       <= 1'b1;
              mem_data_out <= st_merged;
            end else begin
              state       <= RESP;
              mem_address <= '0;
              resp_valid  <= 1'b1;
              resp_rdata  <= ld_ext;
              resp_rd     <= rd_q;
              resp_fault  <= 1'b0;
            end
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end

        WRITE: begin
          state        <= RESP;
          mem_we       <= 1'b0;
          mem_data_out <= 32'd0;
          mem_address  <= '0;
          resp_valid   <= 1'b1;
          resp_rdata   <= 32'd0;
          resp_rd      <= rd_q;
          resp_fault   <= 1'b0;
        end

        RESP: begin
          // resp_rdata/resp_rd/resp_fault keep their value; only the
          // strobe drops.
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end

        default: begin
          state        <= IDLE;
          lat_cnt      <= 4'd0;
          req_ready    <= 1'b1;
          resp_valid   <= 1'b0;
          mem_we       <= 1'b0;
          mem_data_out <= 32'd0;
          mem_address  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int AW = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  // Index 0: RD_LATENCY = 1, index 1: RD_LATENCY = 3.
  logic        req_ready    [2];
  logic        resp_valid   [2];
  logic [31:0] resp_rdata   [2];
  logic [4:0]  resp_rd      [2];
  logic        resp_fault   [2];
  logic [31:0] mem_address  [2];
  logic [31:0] mem_data_out [2];
  logic [31:0] mem_data_in  [2];
  logic        mem_we       [2];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW), .RD_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready[0]), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_rd(resp_rd[0]),
    .resp_fault(resp_fault[0]), .mem_address(mem_address[0]), .mem_data_out(mem_data_out[0]),
    .mem_data_in(mem_data_in[0]), .mem_we(mem_we[0])
  );

  mem_access_unit #(.ADDR_W(AW), .RD_LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready[1]), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_rd(resp_rd[1]),
    .resp_fault(resp_fault[1]), .mem_address(mem_address[1]), .mem_data_out(mem_data_out[1]),
    .mem_data_in(mem_data_in[1]), .mem_we(mem_we[1])
  );

  // Memories: 256 words each. The latency-3 memory returns the word for the
  // address presented two cycles earlier, so sampling before the address has
  // been held for three cycles yields the wrong word.
  logic [31:0] pmem [2][256];
  logic [31:0] ref_mem [256];
  logic [31:0] ah1_0, ah1_1;
  logic        mem_load;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int w = 0; w < 256; w++) begin
        pmem[0][w] <= ref_mem[w];
        pmem[1][w] <= ref_mem[w];
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mem_we[i]) pmem[i][mem_address[i][9:2]] <= mem_data_out[i];
      end
    end
    ah1_0 <= mem_address[1];
    ah1_1 <= ah1_0;
  end

  always_comb begin
    mem_data_in[0] = pmem[0][mem_address[0][9:2]];
    mem_data_in[1] = pmem[1][ah1_1[9:2]];
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int d, input int cyc,
                     input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %08h expected %08h", name, d, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic model_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic illegal, misal;
    if (st) illegal = (f3 > 3'd2);
    else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    misal = ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) || (f3 == 3'd2 && (a % 4 != 0));
    return illegal || misal;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    int sh;
    sh = 8 * int'(a % 4);
    b  = (w >> sh) & 32'h0000_00FF;
    h  = (w >> sh) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_val(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    sh = 8 * int'(a % 4);
    case (f3)
      3'd0: begin
        mask = 32'h0000_00FF << sh;
        return (old & ~mask) | ((wd & 32'h0000_00FF) << sh);
      end
      3'd1: begin
        mask = 32'h0000_FFFF << sh;
        return (old & ~mask) | ((wd & 32'h0000_FFFF) << sh);
      end
      default: return wd;
    endcase
  endfunction

  // ---------------- one request, checked cycle by cycle on both DUTs ----------------
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input logic junk,
                        input logic use_exp, input logic exp_f,
                        input logic [31:0] exp_rdv, input logic [31:0] exp_wrv);
    logic        f;
    logic [31:0] rdv, wv, waddr;
    int          rc [2];
    int          wc [2];
    int          kmax;
    f     = model_fault(st, f3, a);
    rdv   = (f || st) ? 32'd0 : load_val(f3, a, ref_mem[a[9:2]]);
    wv    = store_val(f3, a, ref_mem[a[9:2]], wd);
    if (use_exp) begin
      f   = exp_f;
      rdv = exp_rdv;
      wv  = exp_wrv;
    end
    waddr = {a[31:2], 2'b00};
    for (int i = 0; i < 2; i++) begin
      if (f)                    rc[i] = 1;
      else if (st && f3 == 3'd2) rc[i] = 2;
      else if (st)              rc[i] = lat_of(i) + 2;
      else                      rc[i] = lat_of(i) + 1;
      if (f || !st)             wc[i] = -1;
      else if (f3 == 3'd2)      wc[i] = 1;
      else                      wc[i] = lat_of(i) + 1;
    end
    kmax = rc[1] + 1;

    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("ready_before_req", i, 0, req_ready[i], 1'b1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
    @(posedge clk);
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_store  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rd     = 5'($urandom);
      end
      req_valid = junk && (k < rc[0]);
      for (int i = 0; i < 2; i++) begin
        if (k <= rc[i] + 1) begin
          chk("resp_valid", i, k, resp_valid[i], k == rc[i]);
          if (k == rc[i]) begin
            chk("resp_rdata", i, k, resp_rdata[i], rdv);
            chk("resp_rd", i, k, resp_rd[i], rd);
            chk("resp_fault", i, k, resp_fault[i], f);
          end
          chk("req_ready", i, k, req_ready[i], k > rc[i]);
          chk("mem_we", i, k, mem_we[i], k == wc[i]);
          chk("mem_data_out", i, k, mem_data_out[i], (k == wc[i]) ? wv : 32'd0);
          chk("mem_address", i, k, mem_address[i], (!f && k < rc[i]) ? waddr : 32'd0);
        end
      end
    end
    req_valid = 1'b0;
    if (st && !f) ref_mem[a[9:2]] = wv;
  endtask

  // Reset while a SH is in its READ phase: request dies silently.
  task automatic reset_in_read();
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd1;
    req_addr = 32'h100; req_wdata = 32'h0000_5555; req_rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rd_addr", i, 1, mem_address[i], 32'h100);
      chk("rst_rd_we", i, 1, mem_we[i], 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rd_ready", i, 2, req_ready[i], 1'b1);
      chk("rst_rd_addr0", i, 2, mem_address[i], 32'd0);
    end
    for (int k = 2; k < 7; k++) begin
      if (k > 2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("rst_rd_no_we", i, k, mem_we[i], 1'b0);
        chk("rst_rd_no_resp", i, k, resp_valid[i], 1'b0);
      end
    end
  endtask

  // Reset coinciding with the WRITE cycle of a SW: the write still happens.
  task automatic reset_in_write();
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h10C; req_wdata = 32'h0F1E_2D3C; req_rd = 5'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_wr_we", i, 1, mem_we[i], 1'b1);
      chk("rst_wr_data", i, 1, mem_data_out[i], 32'h0F1E_2D3C);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_wr_we_off", i, 2, mem_we[i], 1'b0);
      chk("rst_wr_no_resp", i, 2, resp_valid[i], 1'b0);
      chk("rst_wr_ready", i, 2, req_ready[i], 1'b1);
    end
    ref_mem[32'h10C >> 2] = 32'h0F1E_2D3C;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } vec_t;

  vec_t vt [18];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;

    vt[0]  = '{1'b0, 3'd0, 32'h100, 32'h0,         5'd1,  1'b0, 32'hFFFF_FFA5, 32'h0};
    vt[1]  = '{1'b0, 3'd4, 32'h103, 32'h0,         5'd2,  1'b0, 32'h0000_0080, 32'h0};
    vt[2]  = '{1'b0, 3'd1, 32'h102, 32'h0,         5'd3,  1'b0, 32'hFFFF_8077, 32'h0};
    vt[3]  = '{1'b0, 3'd5, 32'h100, 32'h0,         5'd4,  1'b0, 32'h0000_F0A5, 32'h0};
    vt[4]  = '{1'b0, 3'd2, 32'h104, 32'h0,         5'd5,  1'b0, 32'h1234_5678, 32'h0};
    vt[5]  = '{1'b1, 3'd0, 32'h101, 32'hDEAD_BE3C, 5'd6,  1'b0, 32'h0,         32'h8077_3CA5};
    vt[6]  = '{1'b0, 3'd2, 32'h100, 32'h0,         5'd7,  1'b0, 32'h8077_3CA5, 32'h0};
    vt[7]  = '{1'b1, 3'd2, 32'h108, 32'hCAFE_BABE, 5'd8,  1'b0, 32'h0,         32'hCAFE_BABE};
    vt[8]  = '{1'b0, 3'd2, 32'h108, 32'h0,         5'd9,  1'b0, 32'hCAFE_BABE, 32'h0};
    vt[9]  = '{1'b1, 3'd1, 32'h102, 32'h1111_BEEF, 5'd10, 1'b0, 32'h0,         32'hBEEF_3CA5};
    vt[10] = '{1'b0, 3'd0, 32'h102, 32'h0,         5'd11, 1'b0, 32'hFFFF_FFEF, 32'h0};
    vt[11] = '{1'b0, 3'd4, 32'h101, 32'h0,         5'd12, 1'b0, 32'h0000_003C, 32'h0};
    vt[12] = '{1'b0, 3'd2, 32'h102, 32'h0,         5'd13, 1'b1, 32'h0,         32'h0};
    vt[13] = '{1'b1, 3'd1, 32'h105, 32'h7777_7777, 5'd14, 1'b1, 32'h0,         32'h0};
    vt[14] = '{1'b0, 3'd3, 32'h100, 32'h0,         5'd15, 1'b1, 32'h0,         32'h0};
    vt[15] = '{1'b1, 3'd5, 32'h100, 32'h1234_1234, 5'd16, 1'b1, 32'h0,         32'h0};
    vt[16] = '{1'b0, 3'd1, 32'h101, 32'h0,         5'd17, 1'b1, 32'h0,         32'h0};
    vt[17] = '{1'b0, 3'd5, 32'h106, 32'h0,         5'd18, 1'b0, 32'h0000_1234, 32'h0};

    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    for (int w = 0; w < 256; w++) ref_mem[w] = $urandom;
    ref_mem[0]          = 32'h0BAD_F00D;
    ref_mem[32'h100>>2] = 32'h8077_F0A5;
    ref_mem[32'h104>>2] = 32'h1234_5678;
    mem_load = 1'b1;
    repeat (3) @(posedge clk);
    mem_load = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_req_ready", i, 0, req_ready[i], 1'b1);
      chk("reset_resp_valid", i, 0, resp_valid[i], 1'b0);
      chk("reset_resp_rdata", i, 0, resp_rdata[i], 32'd0);
      chk("reset_resp_rd", i, 0, resp_rd[i], 5'd0);
      chk("reset_resp_fault", i, 0, resp_fault[i], 1'b0);
      chk("reset_mem_address", i, 0, mem_address[i], 32'd0);
      chk("reset_mem_data_out", i, 0, mem_data_out[i], 32'd0);
      chk("reset_mem_we", i, 0, mem_we[i], 1'b0);
    end
    reset = 1'b0;

    for (int v = 0; v < 18; v++) begin
      do_req(vt[v].st, vt[v].f3, vt[v].addr, vt[v].wd, vt[v].rd, 1'(v % 2),
             1'b1, vt[v].fault, vt[v].rdata, vt[v].wdata);
    end

    reset_in_read();
    do_req(1'b0, 3'd2, 32'h100, 32'h0, 5'd21, 1'b0, 1'b1, 1'b0, 32'hBEEF_3CA5, 32'h0);
    reset_in_write();
    do_req(1'b0, 3'd2, 32'h10C, 32'h0, 5'd22, 1'b0, 1'b1, 1'b0, 32'h0F1E_2D3C, 32'h0);

    for (int n = 0; n < 150; n++) begin
      st = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) begin
        if (st) begin
          f3 = 3'($urandom_range(0, 2));
        end else begin
          int p;
          p  = $urandom_range(0, 4);
          f3 = 3'((p < 3) ? p : p + 1);
        end
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      do_req(st, f3, a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
             1'b0, 1'b0, 32'h0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit between the core's execute stage and the single-port word memory (address/data_out/data_in/we, no byte enables). It takes one RV32I load or store request at a time. It performs word-aligned memory accesses with a parametrised read latency and returns a sign- or zero-extended load result, or a store completion. Sub-word stores are done as read-modify-write. Misaligned or illegal accesses are reported as faults without touching memory.

## Interface
- ADDR_W, 32: address width, ≥ 3.
- RD_LATENCY, 1: cycles the word address is held before `mem_data_in` is sampled, 1..8.
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle, request accepted when `req_valid && req_ready`.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3.
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data; low byte or halfword used for SB/SH.
- `req_rd` in 5: destination register tag, returned unchanged.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and faults.
- `resp_rd` out 5: tag of the completing request.
- `resp_fault` out 1: valid with `resp_valid`; misaligned or illegal funct3.
- `mem_address` out ADDR_W: word address, low two bits always 0.
- `mem_data_out` out 32: write data; 0 when `mem_we` = 0.
- `mem_data_in` in 32: read data.
- `mem_we` out 1: write enable.

## Operation
- States:
  - IDLE: `req_ready` = 1.
  - READ: address held, `mem_we` = 0, latency counter running.
  - WRITE: `mem_we` = 1 for exactly one cycle.
  - RESP: `resp_valid` = 1.
- Request capture: on accept, latch addr, funct3, store, wdata and rd into internal registers. Inputs are ignored until the next accept.
- Fault check, done at accept:
  - Illegal funct3: load 3, 6, 7; store 3..7.
  - Misaligned halfword: LH/LHU/SH with addr[0] = 1.
  - Misaligned word: LW/SW with addr[1:0] ≠ 0.
  - On fault: IDLE→RESP, `resp_fault` = 1, no memory access.
- Load path: IDLE→READ (RD_LATENCY cycles)→RESP.
  - `mem_data_in` is captured at the edge ending the last READ cycle.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- SW path: IDLE→WRITE→RESP. `mem_data_out` = wdata.
- SB/SH path: IDLE→READ→WRITE→RESP.
  - The captured word has the addressed byte or halfword replaced by wdata[7:0] or wdata[15:0]; all other bytes are preserved.
  - The same `mem_address` is held through READ and WRITE.
- RESP always returns to IDLE. There is no response backpressure: the consumer must take `resp_*` in the pulse cycle.
- `resp_rdata`, `resp_rd` and `resp_fault` hold their last value outside the pulse. Only `resp_valid` qualifies them.
- Address wrap: the word address is {addr[ADDR_W-1:2], 2'b00}. There is no increment, so no wrap logic.

## Timing
- Reset values, one edge after `reset` is sampled high:
  - state IDLE, latency counter 0;
  - `req_ready` 1;
  - all other outputs 0.
- Reset mid-operation aborts the request with no response.
  - A WRITE cycle coinciding with `reset` still presents `mem_we` = 1 in that cycle.
  - `mem_we` is 0 from the next cycle.
- Cycle 0 is the accept edge. `resp_valid` is high in cycle:
  - load: RD_LATENCY + 1;
  - SW: 2;
  - SB/SH: RD_LATENCY + 2;
  - fault: 1.
- `req_ready` is 0 from cycle 1 through the RESP cycle and returns to 1 the cycle after RESP.
  - Minimum request spacing = latency + 1.
- `mem_address` is valid from cycle 1 until the end of READ/WRITE and is 0 in IDLE/RESP.
- `req_valid` asserted while `req_ready` = 0 is ignored; the requester must hold it.

## Test plan
- Reset, then memory[0x100] = 0x8077_F0A5 with RD_LATENCY = 1:
  - LB 0x100 → `resp_rdata` 0xFFFF_FFA5 in cycle 2;
  - LBU 0x103 → 0x0000_0080;
  - LH 0x102 → 0xFFFF_8077.
- RD_LATENCY = 3, LW 0x104 with memory = 0x1234_5678:
  - `mem_address` 0x104 held for cycles 1–3;
  - 0x1234_5678 returned in cycle 4.
- SB 0x101, wdata 0xDEAD_BE3C over 0x8077_F0A5:
  - one `mem_we` pulse with `mem_data_out` 0x8077_3CA5;
  - `resp_valid` in cycle RD_LATENCY + 2.
- SW 0x108 with 0xCAFE_BABE: `mem_we` in cycle 1 only, `resp_valid` in cycle 2, `resp_fault` 0.
- LW 0x102 and SH 0x105:
  - `resp_fault` = 1 in cycle 1;
  - `mem_we` never asserted, `mem_address` stays 0;
  - funct3 = 3 load behaves the same.
- SH issued, then `reset` asserted in the READ cycle:
  - no `mem_we` and no `resp_valid`;
  - `req_ready` = 1 after the reset edge;
  - the following LW completes normally.
